// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank sequencer: opcodes, FSM states,
// register-bank control bit positions and decoded instruction layout.
package regbank_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam int unsigned CTRL_RD1 = 0;
  localparam int unsigned CTRL_RD2 = 1;
  localparam int unsigned CTRL_WR  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WAIT,
    S_WRITE,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
  } instr_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'd9) && (op <= 4'd14);
  endfunction

  function automatic logic uses_regbank(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/alu_watchdog.sv
// Counts WAIT cycles without alu_done; expire flags the last permitted cycle.
module alu_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + W'(1);
    end
  end

  // Combinational so the FSM can leave WAIT on the TIMEOUT-th empty cycle.
  assign expire = count && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/regbank_sequencer.sv
// Instruction sequencer driving a register bank and an external ALU:
// IDLE -> READ -> EXEC -> WAIT -> WRITE, with NOP/illegal/HALT handled in IDLE.
module regbank_sequencer
  import regbank_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  addr1,
  output logic [2:0]  addr2,
  output logic [2:0]  addrdest,
  output logic [2:0]  control,
  output logic        enable,
  output logic        alu_start,
  output logic [3:0]  alu_op,
  input  logic        alu_done,
  output logic        err,
  output logic        halted,
  output logic [7:0]  retired
);

  state_t     state;
  state_t     next_state;
  instr_t     cur;
  logic [3:0] op_in;
  logic       accept;
  logic       done_seen;
  logic       wd_load;
  logic       wd_count;
  logic       wd_expire;
  logic       unused_bits;

  assign op_in       = instr[15:12];
  assign accept      = instr_valid && instr_ready;
  assign unused_bits = ^instr[2:0];

  alu_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .load  (wd_load),
    .count (wd_count),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (uses_regbank(op_in)) begin
            next_state = S_READ;
          end else if (op_in == OP_HALT) begin
            next_state = S_HALT;
          end
        end
      end
      S_READ:  next_state = S_EXEC;
      S_EXEC:  next_state = S_WAIT;
      S_WAIT: begin
        if (done_seen) begin
          next_state = S_WRITE;
        end else if (wd_expire) begin
          next_state = S_IDLE;
        end
      end
      S_WRITE: next_state = S_IDLE;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    enable      = 1'b0;
    control     = '0;
    alu_start   = 1'b0;
    halted      = 1'b0;
    wd_load     = 1'b0;
    wd_count    = 1'b0;
    unique case (state)
      S_IDLE: instr_ready = !rst;
      S_READ: begin
        enable            = !rst;
        control[CTRL_RD1] = !rst;
        control[CTRL_RD2] = !rst && (cur.opcode != OP_MOV);
      end
      S_EXEC: begin
        alu_start = 1'b1;
        wd_load   = 1'b1;
      end
      S_WAIT: wd_count = !done_seen && !alu_done;
      S_WRITE: begin
        // Gated with rst so an aborted write never reaches the bank.
        enable           = !rst;
        control[CTRL_WR] = !rst;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= '0;
      done_seen <= 1'b0;
      err       <= 1'b0;
      retired   <= '0;
    end else begin
      err       <= (accept && is_illegal(op_in)) || wd_expire;
      done_seen <= (state == S_WAIT) && !done_seen && alu_done;
      if (accept) begin
        cur <= instr_t'(instr[15:3]);
      end
      if ((accept && (op_in == OP_NOP)) || (state == S_WRITE)) begin
        retired <= retired + 8'd1;
      end
    end
  end

  assign addr1    = cur.src1;
  assign addr2    = cur.src2;
  assign addrdest = cur.dest;
  assign alu_op   = cur.opcode;

endmodule
